// File: rtl/pe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pe_ctrl_pkg
// Shared definitions for the motion-estimation PE-array sequencer.
//   - pe_state_e : sequencer FSM states
//   - REF_*      : reference input-mux codes (up_1, up_8, down_1, down_8)
//   - PIXEL_W    : pixel width used by the PE datapath
// ---------------------------------------------------------------------------
package pe_ctrl_pkg;

    localparam int PIXEL_W = 8;

    // Reference input-mux select codes driven on ref_input_Control.
    localparam logic [1:0] REF_UP1 = 2'b00;
    localparam logic [1:0] REF_UP8 = 2'b01;
    localparam logic [1:0] REF_DN1 = 2'b10;
    localparam logic [1:0] REF_DN8 = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CURR = 3'd1,
        CHG       = 3'd2,
        PREFILL   = 3'd3,
        SEARCH    = 3'd4,
        DONE      = 3'd5
    } pe_state_e;

endpackage

// File: rtl/pe_snake_scan.sv
// ---------------------------------------------------------------------------
// pe_snake_scan
// Row/column position tracker for the full-search snake scan.
// Even columns sweep down (row increments), odd columns sweep up (row
// decrements); the move after the end row of a column is a column step
// (row holds, col + 1).
//
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   clr_i         : hold counters at (0,0) (asserted outside SEARCH)
//   adv_i         : advance to the next candidate position
//   row_o, col_o  : position of the strobe being presented this cycle
//   last_pos_o    : current position is the final candidate of the scan
//   next_ctrl_o   : ref mux code for the strobe that reaches the next position
// ---------------------------------------------------------------------------
module pe_snake_scan
    import pe_ctrl_pkg::*;
#(
    parameter int SR_ROWS = 16,
    parameter int SR_COLS = 16,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [CW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          last_pos_o,
    output logic [1:0]    next_ctrl_o
);

    localparam logic [CW-1:0] ROW_LAST = CW'(SR_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(SR_COLS - 1);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          col_end;

    // End row of a column depends on the sweep direction (col parity).
    assign col_end = col_q[0] ? (row_q == '0) : (row_q == ROW_LAST);

    always_comb begin
        row_d       = row_q;
        col_d       = col_q;
        next_ctrl_o = REF_DN1;
        if (col_end) begin
            col_d       = col_q + 1'b1;
            next_ctrl_o = REF_DN8;
        end else if (col_q[0]) begin
            row_d       = row_q - 1'b1;
            next_ctrl_o = REF_UP1;
        end else begin
            row_d       = row_q + 1'b1;
            next_ctrl_o = REF_DN1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (adv_i) begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o      = row_q;
    assign col_o      = col_q;
    assign last_pos_o = col_end && (col_q == COL_LAST);

endmodule

// File: rtl/pe_array_seq_ctrl.sv
// ---------------------------------------------------------------------------
// pe_array_seq_ctrl
// Sequencer for the motion-estimation PE array. One pass: load the current
// block (BLK*BLK cycles), pulse change_curr, prefill the reference column
// (BLK down shifts), then snake-scan SR_ROWS*SR_COLS candidates, pulsing
// sad_valid one cycle after every search strobe with that strobe's mv.
//
// Optional feature macro: PE_CTRL_ABORT_EN adds the 'abort' input, which
// returns any non-IDLE state to IDLE on the next edge with all strobes low.
//
// Start handshake: start is a level sampled only in IDLE; a pass is accepted
// on the edge where start is high and the FSM is IDLE (busy rises after that
// edge). start seen in any other state, including DONE, is dropped.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   abort               : (PE_CTRL_ABORT_EN only) abandon the current pass
//   start               : begin a pass
//   cb_slot, sad_cb     : CB slot to load / to compare, latched on start
//   busy, done          : non-IDLE indicator, end-of-pass pulse
//   in_curr_enable      : current-pixel load strobe, CB_select its slot
//   change_curr         : pulse after the current load
//   abs_Control         : CB slot feeding the difference units
//   change_ref          : reference shift strobe, ref_input_Control its mux
//   sad_valid, mv_x/y   : valid abs outputs for candidate (mv_x, mv_y)
//   dbg_state           : FSM state for observation
// ---------------------------------------------------------------------------
module pe_array_seq_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int BLK     = 8,
    parameter int SR_ROWS = 16,
    parameter int SR_COLS = 16,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef PE_CTRL_ABORT_EN
    input  logic          abort,
`endif
    input  logic          start,
    input  logic [1:0]    cb_slot,
    input  logic [1:0]    sad_cb,
    output logic          busy,
    output logic          done,
    output logic          in_curr_enable,
    output logic [1:0]    CB_select,
    output logic          change_curr,
    output logic [1:0]    abs_Control,
    output logic          change_ref,
    output logic [1:0]    ref_input_Control,
    output logic          sad_valid,
    output logic [CW-1:0] mv_x,
    output logic [CW-1:0] mv_y,
    output pe_state_e     dbg_state
);

    localparam int               LOAD_LEN  = BLK * BLK;
    localparam int               CNT_W     = $clog2(LOAD_LEN) + 1;
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(BLK - 1);

    pe_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic           in_curr_q;
    logic [1:0]     cb_sel_q;
    logic           change_curr_q;
    logic [1:0]     abs_ctrl_q;
    logic           change_ref_q;
    logic [1:0]     ref_ctrl_q;
    logic           sad_valid_q;
    logic [CW-1:0]  mv_x_q;
    logic [CW-1:0]  mv_y_q;
    logic           done_q;

    logic           abort_hit;
    logic           scan_clr;
    logic           scan_adv;
    logic [CW-1:0]  scan_row;
    logic [CW-1:0]  scan_col;
    logic           scan_last;
    logic [1:0]     scan_ctrl;

`ifdef PE_CTRL_ABORT_EN
    assign abort_hit = abort && (state_q != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Scan counters sit at (0,0) outside SEARCH so each pass starts clean;
    // advancing stops at the final candidate so the column never wraps.
    assign scan_clr = (state_q != SEARCH);
    assign scan_adv = (state_q == SEARCH) && !scan_last;

    pe_snake_scan #(
        .SR_ROWS (SR_ROWS),
        .SR_COLS (SR_COLS),
        .CW      (CW)
    ) u_scan (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (scan_clr),
        .adv_i       (scan_adv),
        .row_o       (scan_row),
        .col_o       (scan_col),
        .last_pos_o  (scan_last),
        .next_ctrl_o (scan_ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            in_curr_q     <= 1'b0;
            cb_sel_q      <= 2'b00;
            change_curr_q <= 1'b0;
            abs_ctrl_q    <= 2'b00;
            change_ref_q  <= 1'b0;
            ref_ctrl_q    <= REF_UP1;
            sad_valid_q   <= 1'b0;
            mv_x_q        <= '0;
            mv_y_q        <= '0;
            done_q        <= 1'b0;
        end else if (abort_hit) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            in_curr_q     <= 1'b0;
            change_curr_q <= 1'b0;
            change_ref_q  <= 1'b0;
            ref_ctrl_q    <= REF_UP1;
            sad_valid_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            change_curr_q <= 1'b0;
            sad_valid_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD_CURR;
                        cnt_q      <= '0;
                        in_curr_q  <= 1'b1;
                        cb_sel_q   <= cb_slot;
                        abs_ctrl_q <= sad_cb;
                    end
                end
                LOAD_CURR: begin
                    if (cnt_q == LOAD_LAST) begin
                        state_q       <= CHG;
                        cnt_q         <= '0;
                        in_curr_q     <= 1'b0;
                        change_curr_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                CHG: begin
                    state_q      <= PREFILL;
                    cnt_q        <= '0;
                    change_ref_q <= 1'b1;
                    ref_ctrl_q   <= REF_DN1;
                end
                PREFILL: begin
                    if (cnt_q == PRE_LAST) begin
                        // First search strobe lands on candidate (0,0): a down_1 shift.
                        state_q    <= SEARCH;
                        cnt_q      <= '0;
                        ref_ctrl_q <= REF_DN1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SEARCH: begin
                    // abs outputs of this strobe appear after the PE ref register.
                    sad_valid_q <= 1'b1;
                    mv_x_q      <= scan_col;
                    mv_y_q      <= scan_row;
                    if (scan_last) begin
                        state_q      <= DONE;
                        change_ref_q <= 1'b0;
                        ref_ctrl_q   <= REF_UP1;
                        done_q       <= 1'b1;
                    end else begin
                        ref_ctrl_q <= scan_ctrl;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy              = (state_q != IDLE);
    assign done              = done_q;
    assign in_curr_enable    = in_curr_q;
    assign CB_select         = cb_sel_q;
    assign change_curr       = change_curr_q;
    assign abs_Control       = abs_ctrl_q;
    assign change_ref        = change_ref_q;
    assign ref_input_Control = ref_ctrl_q;
    assign sad_valid         = sad_valid_q;
    assign mv_x              = mv_x_q;
    assign mv_y              = mv_y_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_array_seq_ctrl
// Directed bench for pe_array_seq_ctrl. Relative cycle r = N means the clock
// period following edge k+N-1, where k is the edge that sampled start.
// ---------------------------------------------------------------------------
module tb_pe_array_seq_ctrl;
    import pe_ctrl_pkg::*;

    localparam int BLK     = 8;
    localparam int SR_ROWS = 16;
    localparam int SR_COLS = 16;
    localparam int CW      = 4;

    localparam int T_LOAD  = BLK * BLK;              // last load cycle (64)
    localparam int T_CHG   = T_LOAD + 1;             // change_curr (65)
    localparam int T_PRE0  = T_CHG + 1;              // first prefill (66)
    localparam int T_SRCH0 = T_PRE0 + BLK;           // first search strobe (74)
    localparam int T_DONE  = T_SRCH0 + SR_ROWS * SR_COLS; // done (330)
    localparam int N_CAND  = SR_ROWS * SR_COLS;

    // ---------------- clock / reset / DUT ----------------
    logic          clk;
    logic          rst_n;
    logic          abort;
    logic          start;
    logic [1:0]    cb_slot;
    logic [1:0]    sad_cb;
    logic          busy;
    logic          done;
    logic          in_curr_enable;
    logic [1:0]    CB_select;
    logic          change_curr;
    logic [1:0]    abs_Control;
    logic          change_ref;
    logic [1:0]    ref_input_Control;
    logic          sad_valid;
    logic [CW-1:0] mv_x;
    logic [CW-1:0] mv_y;
    pe_state_e     dbg_state;
    logic [19:0]   out_vec;

    int cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    pe_array_seq_ctrl #(
        .BLK     (BLK),
        .SR_ROWS (SR_ROWS),
        .SR_COLS (SR_COLS),
        .CW      (CW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
`ifdef PE_CTRL_ABORT_EN
        .abort             (abort),
`endif
        .start             (start),
        .cb_slot           (cb_slot),
        .sad_cb            (sad_cb),
        .busy              (busy),
        .done              (done),
        .in_curr_enable    (in_curr_enable),
        .CB_select         (CB_select),
        .change_curr       (change_curr),
        .abs_Control       (abs_Control),
        .change_ref        (change_ref),
        .ref_input_Control (ref_input_Control),
        .sad_valid         (sad_valid),
        .mv_x              (mv_x),
        .mv_y              (mv_y),
        .dbg_state         (dbg_state)
    );

    assign out_vec = {busy, done, in_curr_enable, CB_select, change_curr, abs_Control,
                      change_ref, ref_input_Control, sad_valid, mv_x, mv_y};

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;
    int k       = 0;
    bit mon_en  = 1'b0;
    logic [1:0] exp_cb;
    logic [1:0] exp_sad;

    int ice_cnt, ice_out, cb_bad, cc_cnt, cc_r, done_cnt, done_r;
    int sv_cnt, sv_first, sv_last, up_cnt, up8_cnt, dn_cnt, step_cnt;
    int pf_bad, abs_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Expected candidate order of one full snake scan, pushed at start.
    task automatic start_pass(input logic [1:0] cb, input logic [1:0] sc);
        ice_cnt = 0; ice_out = 0; cb_bad = 0; cc_cnt = 0; cc_r = 0;
        done_cnt = 0; done_r = 0; sv_cnt = 0; sv_first = 0; sv_last = 0;
        up_cnt = 0; up8_cnt = 0; dn_cnt = 0; step_cnt = 0; pf_bad = 0; abs_bad = 0;
        exp_q.delete();
        for (int c = 0; c < SR_COLS; c++) begin
            for (int i = 0; i < SR_ROWS; i++) begin
                int rw;
                rw = (c % 2 == 0) ? i : (SR_ROWS - 1 - i);
                exp_q.push_back({CW'(c), CW'(rw)});
            end
        end
        exp_cb  = cb;
        exp_sad = sc;
        cb_slot = cb;
        sad_cb  = sc;
        start   = 1'b1;
        k       = cyc + 1;
        mon_en  = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go_to(input int t);
        while (cyc - k + 1 < t) @(negedge clk);
    endtask

    task automatic pass_stats(input string p);
        check({p, "_load_cycles"}, ice_cnt, T_LOAD);
        check({p, "_load_outside"}, ice_out, 0);
        check({p, "_cb_select"}, cb_bad, 0);
        check({p, "_chg_count"}, cc_cnt, 1);
        check({p, "_chg_cycle"}, cc_r, T_CHG);
        check({p, "_done_count"}, done_cnt, 1);
        check({p, "_done_cycle"}, done_r, T_DONE);
        check({p, "_sv_count"}, sv_cnt, N_CAND);
        check({p, "_sv_first"}, sv_first, T_SRCH0 + 1);
        check({p, "_sv_last"}, sv_last, T_DONE);
        check({p, "_col_steps"}, step_cnt, SR_COLS - 1);
        check({p, "_up1_moves"}, up_cnt, (SR_COLS / 2) * (SR_ROWS - 1));
        check({p, "_dn1_moves"}, dn_cnt, BLK + SR_ROWS + (SR_COLS / 2 - 1) * (SR_ROWS - 1));
        check({p, "_up8_moves"}, up8_cnt, 0);
        check({p, "_prefill"}, pf_bad, 0);
        check({p, "_abs_ctrl"}, abs_bad, 0);
        check({p, "_queue_left"}, exp_q.size(), 0);
    endtask

    // ---------------- monitor (samples 1 time unit after each edge) ----------------
    always @(posedge clk) begin
        int r;
        logic [7:0] exp_mv;
        #1;
        if (mon_en) begin
            r = cyc - k + 1;
            if (in_curr_enable) begin
                ice_cnt++;
                if (r < 1 || r > T_LOAD) ice_out++;
                if (CB_select !== exp_cb) cb_bad++;
            end
            if (change_curr) begin
                cc_cnt++;
                cc_r = r;
            end
            if (done) begin
                done_cnt++;
                done_r = r;
            end
            if (change_ref) begin
                case (ref_input_Control)
                    REF_UP1: up_cnt++;
                    REF_UP8: up8_cnt++;
                    REF_DN1: dn_cnt++;
                    default: step_cnt++;
                endcase
            end
            if (r >= T_PRE0 && r < T_SRCH0 && !(change_ref && ref_input_Control == REF_DN1)) pf_bad++;
            if (r >= T_SRCH0 && r <= T_DONE && abs_Control !== exp_sad) abs_bad++;
            if (sad_valid) begin
                if (sv_cnt == 0) sv_first = r;
                sv_last = r;
                sv_cnt++;
                check("sv_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    exp_mv = exp_q.pop_front();
                    check("mv", {mv_x, mv_y}, exp_mv);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst_n   = 1'b0;
        abort   = 1'b0;
        start   = 1'b0;
        cb_slot = 2'b00;
        sad_cb  = 2'b00;
        exp_cb  = 2'b00;
        exp_sad = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_vec, 0);
        check("reset_state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Pass A: full pass, stray start at r=100 must be ignored.
        start_pass(2'd2, 2'd2);
        go_to(50);
        check("A_busy_mid", busy, 1);
        check("A_state_load", dbg_state, LOAD_CURR);
        go_to(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        go_to(T_DONE + 20);
        pass_stats("A");
        check("A_idle_after", busy, 0);
        check("A_abs_hold", abs_Control, 2);
        check("A_cb_hold", CB_select, 2);

        // Pass B: synchronous reset at r=200 aborts the pass.
        start_pass(2'd1, 2'd3);
        go_to(200);
        rst_n = 1'b0;
        @(negedge clk);
        check("B_rst_outputs", out_vec, 0);
        check("B_rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        go_to(T_DONE + 5);
        check("B_no_done", done_cnt, 0);
        check("B_sv_count", sv_cnt, 200 - T_SRCH0);
        check("B_load_cycles", ice_cnt, T_LOAD);
        check("B_idle", busy, 0);

        // Pass C: normal pass after the reset.
        start_pass(2'd3, 2'd1);
        go_to(T_DONE + 3);
        pass_stats("C");

        // Pass D: start held high restarts one cycle after IDLE is reached.
        start_pass(2'd0, 2'd2);
        start = 1'b1;
        go_to(T_DONE);
        check("D_done", done, 1);
        check("D_sv_count", sv_cnt, N_CAND);
        go_to(T_DONE + 1);
        check("D_idle_busy", busy, 0);
        check("D_idle_load", in_curr_enable, 0);
        go_to(T_DONE + 2);
        check("D_restart_load", in_curr_enable, 1);
        check("D_restart_busy", busy, 1);
        check("D_done_count", done_cnt, 1);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef PE_CTRL_ABORT_EN
        // Abort during SEARCH at r=80.
        start_pass(2'd1, 2'd1);
        go_to(80);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("E_abort_busy", busy, 0);
        check("E_abort_ref", change_ref, 0);
        check("E_abort_sv", sad_valid, 0);
        check("E_abort_state", dbg_state, IDLE);
        go_to(T_DONE + 3);
        check("E_no_done", done_cnt, 0);
        check("E_sv_count", sv_cnt, 80 - T_SRCH0);

        // abort in IDLE alongside start does not block the pass.
        abort = 1'b1;
        start_pass(2'd2, 2'd0);
        abort = 1'b0;
        check("E_idle_abort_ignored", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
